// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one combinational ALU between two requesters
// (req0: execute stage, req1: address/branch unit).
//
// Round-robin grant on ties, valid/ready handshakes on both sides, and a
// registered result held until the owning requester consumes it. A release
// and a new accept may happen on the same edge, so one op per cycle is
// sustained while the response side keeps ready high.
//
// Ports
//   clk, rst_n                      clock (rising), async active-low reset
//   reqN_valid/ready/op/left/right  request side, N = 0,1
//   rspN_valid/ready                response handshake; rsp_result is shared,
//                                   its owner is whichever rspN_valid is high
//   alu_op/left/right, alu_result   connection to the external ALU
//
// Optional feature (macro ALU_ARB_PERF_EN): adds perf_grant0, perf_grant1
// (accepted ops per requester) and perf_conflict (cycles with both requests
// valid while the arbiter is free). Counters wrap modulo 2^CNT_W.

`ifndef ALU_OP_LENGTH
`define ALU_OP_LENGTH 4
`endif

module alu_arbiter #(
  parameter int OP_W   = `ALU_OP_LENGTH,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [OP_W-1:0]   req0_op,
  input  logic [DATA_W-1:0] req0_left,
  input  logic [DATA_W-1:0] req0_right,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [OP_W-1:0]   req1_op,
  input  logic [DATA_W-1:0] req1_left,
  input  logic [DATA_W-1:0] req1_right,
  output logic              rsp0_valid,
  input  logic              rsp0_ready,
  output logic              rsp1_valid,
  input  logic              rsp1_ready,
  output logic [DATA_W-1:0] rsp_result,
  output logic [OP_W-1:0]   alu_op,
  output logic [DATA_W-1:0] alu_left,
  output logic [DATA_W-1:0] alu_right,
  input  logic [DATA_W-1:0] alu_result
`ifdef ALU_ARB_PERF_EN
  ,
  output logic [CNT_W-1:0]  perf_grant0,
  output logic [CNT_W-1:0]  perf_grant1,
  output logic [CNT_W-1:0]  perf_conflict
`endif
);

  typedef enum logic {IDLE, RESP} state_t;

  typedef struct packed {
    logic [OP_W-1:0]   op;
    logic [DATA_W-1:0] left;
    logic [DATA_W-1:0] right;
  } req_t;

  state_t state, state_d;
  logic   owner;       // requester that owns the held result
  logic   last_grant;  // loser of the next tie is this one
  logic   owner_ready, free, both, grant, accept;
  req_t   req0, req1, sel;

  assign req0 = '{op: req0_op, left: req0_left, right: req0_right};
  assign req1 = '{op: req1_op, left: req1_left, right: req1_right};

  // Next-state / grant logic. rst_n gates free so both readys stay low
  // while reset is asserted even though the state register reads IDLE.
  always_comb begin
    state_d     = state;
    owner_ready = owner ? rsp1_ready : rsp0_ready;
    free        = rst_n && ((state == IDLE) || owner_ready);
    both        = req0_valid && req1_valid;
    grant       = both ? ~last_grant : req1_valid;
    accept      = free && (req0_valid || req1_valid);
    if (accept)
      state_d = RESP;
    else if (state == RESP && owner_ready)
      state_d = IDLE;
  end

  assign req0_ready = accept && !grant;
  assign req1_ready = accept && grant;

  // Without a grant the ALU still sees req0's operands; the result is unused.
  assign sel       = (accept && grant) ? req1 : req0;
  assign alu_op    = sel.op;
  assign alu_left  = sel.left;
  assign alu_right = sel.right;

  assign rsp0_valid = (state == RESP) && !owner;
  assign rsp1_valid = (state == RESP) && owner;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      owner      <= 1'b0;
      last_grant <= 1'b1;
      rsp_result <= '0;
    end else begin
      state <= state_d;
      if (accept) begin
        rsp_result <= alu_result;
        owner      <= grant;
        last_grant <= grant;
      end
    end
  end

`ifdef ALU_ARB_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_grant0   <= '0;
      perf_grant1   <= '0;
      perf_conflict <= '0;
    end else begin
      if (req0_ready)  perf_grant0   <= perf_grant0 + 1'b1;
      if (req1_ready)  perf_grant1   <= perf_grant1 + 1'b1;
      if (free && both) perf_conflict <= perf_conflict + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: self-checking bench for alu_arbiter. Provides a small
// behavioural ALU (ADD, SUB, SLT, SRA, AND; others return 0), directed
// scenarios, and a randomized run checked against per-requester scoreboards.

module tb_alu_arbiter;

  localparam int OW = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req0_valid = 0, req1_valid = 0;
  logic        req0_ready, req1_ready;
  logic [OW-1:0] req0_op = '0, req1_op = '0;
  logic [31:0] req0_left = '0, req0_right = '0, req1_left = '0, req1_right = '0;
  logic        rsp0_valid, rsp1_valid;
  logic        rsp0_ready = 0, rsp1_ready = 0;
  logic [31:0] rsp_result;
  logic [OW-1:0] alu_op;
  logic [31:0] alu_left, alu_right, alu_result;
`ifdef ALU_ARB_PERF_EN
  logic [31:0] perf_grant0, perf_grant1, perf_conflict;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] alu_f(logic [OW-1:0] op, logic [31:0] a, logic [31:0] b);
    case (op)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd2:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd3:    return $unsigned($signed(a) >>> b[4:0]);
      4'd4:    return a & b;
      default: return 32'd0;
    endcase
  endfunction

  assign alu_result = alu_f(alu_op, alu_left, alu_right);

  alu_arbiter #(.OP_W(OW), .DATA_W(32), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_left(req0_left), .req0_right(req0_right),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_left(req1_left), .req1_right(req1_right),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
    .rsp_result(rsp_result),
    .alu_op(alu_op), .alu_left(alu_left), .alu_right(alu_right),
    .alu_result(alu_result)
`ifdef ALU_ARB_PERF_EN
    , .perf_grant0(perf_grant0), .perf_grant1(perf_grant1), .perf_conflict(perf_conflict)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 0;
    req0_valid = 0; req1_valid = 0; rsp0_ready = 0; rsp1_ready = 0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1;
    tick();
  endtask

  task automatic set0(logic [OW-1:0] op, logic [31:0] a, logic [31:0] b);
    req0_valid = 1; req0_op = op; req0_left = a; req0_right = b;
  endtask

  task automatic set1(logic [OW-1:0] op, logic [31:0] a, logic [31:0] b);
    req1_valid = 1; req1_op = op; req1_left = a; req1_right = b;
  endtask

  task automatic test_reset();
    rst_n = 0;
    set0(4'd0, 32'd1, 32'd2);
    set1(4'd1, 32'd3, 32'd4);
    rsp0_ready = 1; rsp1_ready = 1;
    @(negedge clk);
    total++;
    if ({req0_ready, req1_ready} !== 2'b00) begin
      bad++; $display("FAIL reset_readys got=%b want=00", {req0_ready, req1_ready});
    end
    total++;
    if ({rsp0_valid, rsp1_valid} !== 2'b00 || rsp_result !== 32'd0) begin
      bad++; $display("FAIL reset_rsp got v=%b r=%h want v=00 r=0", {rsp0_valid, rsp1_valid}, rsp_result);
    end
    do_reset();
  endtask

  task automatic test_single();
    do_reset();
    set0(4'd0, 32'd5, 32'd7);
    rsp0_ready = 1;
    @(negedge clk);
    total++;
    if ({req0_ready, req1_ready} !== 2'b10 || alu_left !== 32'd5 || alu_right !== 32'd7) begin
      bad++; $display("FAIL single_grant got rdy=%b l=%h r=%h want rdy=10 l=5 r=7",
                      {req0_ready, req1_ready}, alu_left, alu_right);
    end
    tick();
    req0_valid = 0;
    @(negedge clk);
    total++;
    if ({rsp0_valid, rsp1_valid} !== 2'b10 || rsp_result !== 32'd12) begin
      bad++; $display("FAIL single_rsp got v=%b r=%0d want v=10 r=12", {rsp0_valid, rsp1_valid}, rsp_result);
    end
    tick();
    @(negedge clk);
    total++;
    if ({rsp0_valid, rsp1_valid} !== 2'b00) begin
      bad++; $display("FAIL single_idle got v=%b want 00", {rsp0_valid, rsp1_valid});
    end
  endtask

  task automatic test_tie();
    do_reset();
    set0(4'd1, 32'd10, 32'd3);
    set1(4'd2, 32'hFFFF_FFFF, 32'd1);
    rsp0_ready = 1; rsp1_ready = 1;
    @(negedge clk);
    total++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      bad++; $display("FAIL tie_first got=%b want=10", {req0_ready, req1_ready});
    end
    tick();
    req0_valid = 0;
    @(negedge clk);
    total++;
    if ({rsp0_valid, rsp1_valid, req1_ready} !== 3'b101 || rsp_result !== 32'd7) begin
      bad++; $display("FAIL tie_r0 got v=%b rdy1=%b r=%0d want v=10 rdy1=1 r=7",
                      {rsp0_valid, rsp1_valid}, req1_ready, rsp_result);
    end
    tick();
    req1_valid = 0;
    @(negedge clk);
    total++;
    if ({rsp0_valid, rsp1_valid} !== 2'b01 || rsp_result !== 32'd1) begin
      bad++; $display("FAIL tie_r1 got v=%b r=%0d want v=01 r=1", {rsp0_valid, rsp1_valid}, rsp_result);
    end
    tick();
  endtask

  task automatic test_stall();
    do_reset();
    set1(4'd3, 32'h8000_0000, 32'd4);
    rsp1_ready = 0; rsp0_ready = 1;
    @(negedge clk);
    total++;
    if (req1_ready !== 1'b1) begin
      bad++; $display("FAIL stall_accept got=%b want=1", req1_ready);
    end
    tick();
    req1_valid = 0;
    set0(4'd0, 32'd1, 32'd2);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++;
      if (rsp1_valid !== 1'b1 || rsp_result !== 32'hF800_0000 || {req0_ready, req1_ready} !== 2'b00) begin
        bad++; $display("FAIL stall_hold%0d got v1=%b r=%h rdy=%b want v1=1 r=f8000000 rdy=00",
                        i, rsp1_valid, rsp_result, {req0_ready, req1_ready});
      end
      tick();
    end
    rsp1_ready = 1;
    @(negedge clk);
    total++;
    if (req0_ready !== 1'b1) begin
      bad++; $display("FAIL stall_release got rdy0=%b want 1", req0_ready);
    end
    tick();
    req0_valid = 0;
    @(negedge clk);
    total++;
    if ({rsp0_valid, rsp1_valid} !== 2'b10 || rsp_result !== 32'd3) begin
      bad++; $display("FAIL stall_switch got v=%b r=%0d want v=10 r=3", {rsp0_valid, rsp1_valid}, rsp_result);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_r;
    int          exp_o;
    do_reset();
    set0(OW'($urandom_range(0, 4)), $urandom, $urandom);
    set1(OW'($urandom_range(0, 4)), $urandom, $urandom);
    rsp0_ready = 1; rsp1_ready = 1;
    exp_r = 0; exp_o = -1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (exp_o >= 0) begin
        total++;
        if ({rsp0_valid, rsp1_valid} !== (exp_o == 0 ? 2'b10 : 2'b01) || rsp_result !== exp_r) begin
          bad++; $display("FAIL b2b_rsp%0d got v=%b r=%h want owner=%0d r=%h",
                          i, {rsp0_valid, rsp1_valid}, rsp_result, exp_o, exp_r);
        end
      end
      total++;
      if ({req0_ready, req1_ready} !== ((i % 2 == 0) ? 2'b10 : 2'b01)) begin
        bad++; $display("FAIL b2b_grant%0d got=%b want grant %0d", i, {req0_ready, req1_ready}, i % 2);
      end
      exp_o = i % 2;
      exp_r = (exp_o == 0) ? alu_f(req0_op, req0_left, req0_right) : alu_f(req1_op, req1_left, req1_right);
      tick();
      if (i == 3) begin
        req0_valid = 0; req1_valid = 0;
      end else if (exp_o == 0) set0(OW'($urandom_range(0, 4)), $urandom, $urandom);
      else set1(OW'($urandom_range(0, 4)), $urandom, $urandom);
    end
    @(negedge clk);
    total++;
    if ({rsp0_valid, rsp1_valid} !== 2'b01 || rsp_result !== exp_r) begin
      bad++; $display("FAIL b2b_last got v=%b r=%h want v=01 r=%h", {rsp0_valid, rsp1_valid}, rsp_result, exp_r);
    end
`ifdef ALU_ARB_PERF_EN
    total++;
    if (perf_grant0 !== 32'd2 || perf_grant1 !== 32'd2 || perf_conflict !== 32'd4) begin
      bad++; $display("FAIL perf got g0=%0d g1=%0d c=%0d want 2 2 4", perf_grant0, perf_grant1, perf_conflict);
    end
`endif
    tick();
  endtask

  task automatic test_reset_mid();
    do_reset();
    set0(4'd0, 32'd100, 32'd1);
    rsp0_ready = 0;
    tick();
    req0_valid = 0;
    @(negedge clk);
    total++;
    if (rsp0_valid !== 1'b1 || rsp_result !== 32'd101) begin
      bad++; $display("FAIL rmid_held got v0=%b r=%0d want 1 101", rsp0_valid, rsp_result);
    end
    #2 rst_n = 0;
    #1;
    total++;
    if (rsp0_valid !== 1'b0 || rsp_result !== 32'd0) begin
      bad++; $display("FAIL rmid_drop got v0=%b r=%0d want 0 0", rsp0_valid, rsp_result);
    end
    @(negedge clk);
    rst_n = 1;
    tick();
    set0(4'd0, 32'd1, 32'd1);
    set1(4'd0, 32'd2, 32'd2);
    rsp0_ready = 1;
    @(negedge clk);
    total++;
    if ({req0_ready, req1_ready, rsp0_valid} !== 3'b100) begin
      bad++; $display("FAIL rmid_tie got rdy=%b v0=%b want rdy=10 v0=0", {req0_ready, req1_ready}, rsp0_valid);
    end
    tick();
    req0_valid = 0; req1_valid = 0;
    rsp1_ready = 1;
    tick();
    tick();
  endtask

  task automatic test_undef_op();
    do_reset();
    set0(4'd0, 32'd5, 32'd7);
    rsp0_ready = 1; rsp1_ready = 1;
    tick();
    req0_valid = 0;
    set1(4'd15, 32'hDEAD_BEEF, 32'h1234_5678);
    @(negedge clk);
    total++;
    if (rsp_result !== 32'd12 || req1_ready !== 1'b1) begin
      bad++; $display("FAIL undef_pre got r=%0d rdy1=%b want 12 1", rsp_result, req1_ready);
    end
    tick();
    req1_valid = 0;
    @(negedge clk);
    total++;
    if (rsp1_valid !== 1'b1 || rsp_result !== 32'd0) begin
      bad++; $display("FAIL undef_rsp got v1=%b r=%h want 1 0", rsp1_valid, rsp_result);
    end
    tick();
  endtask

  task automatic test_random();
    logic [31:0] q0[$];
    logic [31:0] q1[$];
    bit          last, acc0, acc1, fr, g;
    logic [1:0]  exp_rdy;
    int          errs;
    do_reset();
    last = 1; acc0 = 1; acc1 = 1; errs = 0;
    req0_valid = 0; req1_valid = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (acc0 || !req0_valid) begin
        req0_valid = ($urandom_range(0, 2) != 0);
        req0_op = OW'($urandom_range(0, 5)); req0_left = $urandom; req0_right = $urandom;
      end
      if (acc1 || !req1_valid) begin
        req1_valid = ($urandom_range(0, 2) != 0);
        req1_op = OW'($urandom_range(0, 5)); req1_left = $urandom; req1_right = $urandom;
      end
      if (cyc >= 380) begin
        req0_valid = 0; req1_valid = 0;
      end
      rsp0_ready = ($urandom_range(0, 3) != 0);
      rsp1_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      // Pending responses must be visible exactly when the scoreboard holds one.
      total++;
      if (rsp0_valid !== (q0.size() != 0) || rsp1_valid !== (q1.size() != 0)) begin
        bad++; errs++;
        if (errs < 10) $display("FAIL rnd_pending cyc=%0d got v=%b want v=%b", cyc,
                                {rsp0_valid, rsp1_valid}, {q0.size() != 0, q1.size() != 0});
      end
      if (rsp0_valid && q0.size() != 0) begin
        total++;
        if (rsp_result !== q0[0]) begin
          bad++; errs++;
          if (errs < 10) $display("FAIL rnd_r0 cyc=%0d got=%h want=%h", cyc, rsp_result, q0[0]);
        end
      end
      if (rsp1_valid && q1.size() != 0) begin
        total++;
        if (rsp_result !== q1[0]) begin
          bad++; errs++;
          if (errs < 10) $display("FAIL rnd_r1 cyc=%0d got=%h want=%h", cyc, rsp_result, q1[0]);
        end
      end
      // Free when nothing is held or the held result is consumed this cycle.
      fr = (q0.size() == 0 && q1.size() == 0) || (q0.size() != 0 && rsp0_ready) ||
           (q1.size() != 0 && rsp1_ready);
      if (q0.size() != 0 && rsp0_ready) void'(q0.pop_front());
      if (q1.size() != 0 && rsp1_ready) void'(q1.pop_front());
      g = (req0_valid && req1_valid) ? !last : req1_valid;
      exp_rdy = 2'b00;
      if (fr && (req0_valid || req1_valid)) exp_rdy = g ? 2'b01 : 2'b10;
      total++;
      if ({req0_ready, req1_ready} !== exp_rdy) begin
        bad++; errs++;
        if (errs < 10) $display("FAIL rnd_grant cyc=%0d got=%b want=%b", cyc, {req0_ready, req1_ready}, exp_rdy);
      end
      acc0 = (exp_rdy == 2'b10);
      acc1 = (exp_rdy == 2'b01);
      if (acc0) begin q0.push_back(alu_f(req0_op, req0_left, req0_right)); last = 0; end
      if (acc1) begin q1.push_back(alu_f(req1_op, req1_left, req1_right)); last = 1; end
      tick();
    end
    rsp0_ready = 1; rsp1_ready = 1;
    tick();
    tick();
    @(negedge clk);
    total++;
    if ({rsp0_valid, rsp1_valid} !== 2'b00) begin
      bad++; $display("FAIL rnd_drain got v=%b want 00", {rsp0_valid, rsp1_valid});
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_tie();
    test_stall();
    test_back_to_back();
    test_reset_mid();
    test_undef_op();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout got=running want=finished");
    $fatal(1);
  end

endmodule
